// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - opcodes, state encoding and control codes for the multicycle MIPS controller
// Optional BNE support is enabled with MIPS_BNE_EN.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_ALUWB   = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
`ifdef MIPS_BNE_EN
    , S_BNEEX = 4'd12
`endif
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] ALUB_B     = 2'b00;
  localparam logic [1:0] ALUB_FOUR  = 2'b01;
  localparam logic [1:0] ALUB_IMM   = 2'b10;
  localparam logic [1:0] ALUB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
`ifdef MIPS_BNE_EN
    logic       branch_ne;
`endif
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       branch;
  } ctrl_t;

endpackage

// File: rtl/mips_mc_outdec.sv
// rtl/mips_mc_outdec.sv - Moore output decode from controller state (MIPS_BNE_EN adds BNEEX)
module mips_mc_outdec
  import mips_pkg::*;
(
  input  state_t i_state,
  input  logic   i_mem_ready,
  output ctrl_t  o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.alu_src_b = ALUB_FOUR;
        o_ctrl.alu_op    = ALUOP_ADD;
        o_ctrl.pc_src    = PCSRC_ALU;
        // PC and IR load only on the cycle the fetch completes
        o_ctrl.ir_write  = i_mem_ready;
        o_ctrl.pc_write  = i_mem_ready;
      end
      S_DECODE: begin
        o_ctrl.alu_src_b = ALUB_IMMSH;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = ALUB_IMM;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: o_ctrl.iord = 1'b1;
      S_MEMWB: begin
        o_ctrl.mem_to_reg = 1'b1;
        o_ctrl.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        o_ctrl.iord      = 1'b1;
        o_ctrl.mem_write = 1'b1;
      end
      S_RTYPEEX: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = ALUB_B;
        o_ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        o_ctrl.reg_dst   = 1'b1;
        o_ctrl.reg_write = 1'b1;
      end
      S_BEQEX: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = ALUB_B;
        o_ctrl.alu_op    = ALUOP_SUB;
        o_ctrl.pc_src    = PCSRC_ALUOUT;
        o_ctrl.branch    = 1'b1;
      end
`ifdef MIPS_BNE_EN
      S_BNEEX: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = ALUB_B;
        o_ctrl.alu_op    = ALUOP_SUB;
        o_ctrl.pc_src    = PCSRC_ALUOUT;
        o_ctrl.branch    = 1'b1;
        o_ctrl.branch_ne = 1'b1;
      end
`endif
      S_ADDIWB: o_ctrl.reg_write = 1'b1;
      S_JEX: begin
        o_ctrl.pc_src   = PCSRC_JUMP;
        o_ctrl.pc_write = 1'b1;
      end
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips_mc_control.sv
// rtl/mips_mc_control.sv - multicycle MIPS main control FSM (MIPS_BNE_EN adds BNE and BranchNe)
module mips_mc_control
  import mips_pkg::*;
#(
  parameter int MEM_WAIT = 1
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic [5:0] Op,
  input  logic       MemReady,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       AluSrcA,
  output logic [1:0] AluSrcB,
  output logic [1:0] AluOp,
  output logic [1:0] PCSrc,
  output logic       PCWrite,
  output logic       Branch,
`ifdef MIPS_BNE_EN
  output logic       BranchNe,
`endif
  output logic       IllegalOp
);

  state_t r_state;
  state_t w_next;
  logic   w_mem_rdy;
  logic   w_illegal;
  ctrl_t  w_dec;
  ctrl_t  w_ctrl;

  assign w_mem_rdy = (MEM_WAIT != 0) ? MemReady : 1'b1;

  always_ff @(posedge Clk) begin
    if (!Rst_n) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = S_FETCH;
    w_illegal = 1'b0;
    case (r_state)
      S_FETCH:  w_next = w_mem_rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_RTYPEEX;
          OP_BEQ:       w_next = S_BEQEX;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JEX;
`ifdef MIPS_BNE_EN
          OP_BNE:       w_next = S_BNEEX;
`endif
          default: begin
            w_next    = S_FETCH;
            w_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR:  w_next = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   w_next = w_mem_rdy ? S_MEMWB : S_MEMRD;
      S_MEMWR:   w_next = w_mem_rdy ? S_FETCH : S_MEMWR;
      S_RTYPEEX: w_next = S_ALUWB;
      S_ADDIEX:  w_next = S_ADDIWB;
      default:   w_next = S_FETCH;
    endcase
  end

  mips_mc_outdec u_outdec (
    .i_state     (r_state),
    .i_mem_ready (w_mem_rdy),
    .o_ctrl      (w_dec)
  );

  // Reset masks every strobe and select combinationally, not just the state
  assign w_ctrl    = Rst_n ? w_dec : '0;
  assign IllegalOp = Rst_n & w_illegal;

  assign IorD     = w_ctrl.iord;
  assign MemWrite = w_ctrl.mem_write;
  assign IRWrite  = w_ctrl.ir_write;
  assign RegDst   = w_ctrl.reg_dst;
  assign MemtoReg = w_ctrl.mem_to_reg;
  assign RegWrite = w_ctrl.reg_write;
  assign AluSrcA  = w_ctrl.alu_src_a;
  assign AluSrcB  = w_ctrl.alu_src_b;
  assign AluOp    = w_ctrl.alu_op;
  assign PCSrc    = w_ctrl.pc_src;
  assign PCWrite  = w_ctrl.pc_write;
  assign Branch   = w_ctrl.branch;
`ifdef MIPS_BNE_EN
  assign BranchNe = w_ctrl.branch_ne;
`endif

endmodule

// File: tb/tb_mips_mc_control.sv
// tb/tb_mips_mc_control.sv - scoreboard bench for mips_mc_control (honours MIPS_BNE_EN)
module tb_mips_mc_control;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic [5:0] Op = 6'd0;
  logic       MemReady = 1'b0;
  logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, AluSrcA;
  logic [1:0] AluSrcB, AluOp, PCSrc;
  logic       PCWrite, Branch, IllegalOp;
  logic       w_bne;

`ifdef MIPS_BNE_EN
  logic BranchNe;
  assign w_bne = BranchNe;
  localparam bit BNE_ON = 1'b1;
`else
  assign w_bne = 1'b0;
  localparam bit BNE_ON = 1'b0;
`endif

  always #5 Clk = ~Clk;

  mips_mc_control #(.MEM_WAIT(1)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Op(Op), .MemReady(MemReady),
    .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .AluSrcA(AluSrcA),
    .AluSrcB(AluSrcB), .AluOp(AluOp), .PCSrc(PCSrc), .PCWrite(PCWrite),
    .Branch(Branch),
`ifdef MIPS_BNE_EN
    .BranchNe(BranchNe),
`endif
    .IllegalOp(IllegalOp)
  );

  // One step of an instruction as seen by the datapath: outputs when memory
  // is ready, outputs while stalled, whether it stalls, whether Op matters.
  typedef struct {
    logic [16:0] rdy;
    logic [16:0] stl;
    bit          waits;
    bit          need_op;
  } step_t;

  step_t       plan[$];
  logic [16:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;

  function automatic logic [16:0] mk(bit iord = 0, bit memw = 0, bit irw = 0,
      bit rdst = 0, bit m2r = 0, bit regw = 0, bit asa = 0, bit [1:0] asb = 0,
      bit [1:0] aop = 0, bit [1:0] pcs = 0, bit pcw = 0, bit br = 0,
      bit ill = 0, bit bne = 0);
    return {bne, iord, memw, irw, rdst, m2r, regw, asa, asb, aop, pcs, pcw, br, ill};
  endfunction

  function automatic step_t st(logic [16:0] r, logic [16:0] s, bit w, bit n);
    step_t x;
    x.rdy = r; x.stl = s; x.waits = w; x.need_op = n;
    return x;
  endfunction

  function automatic void build(logic [5:0] op);
    bit legal;
    logic [16:0] v;
    legal = (op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010})
            || (BNE_ON && op == 6'b000101);
    plan.delete();
    plan.push_back(st(mk(.asb(2'b01), .irw(1), .pcw(1)), mk(.asb(2'b01)), 1, 0));
    v = mk(.asb(2'b11), .ill(!legal));
    plan.push_back(st(v, v, 0, 1));
    case (op)
      6'b100011: begin
        v = mk(.asa(1), .asb(2'b10)); plan.push_back(st(v, v, 0, 1));
        v = mk(.iord(1));             plan.push_back(st(v, v, 1, 0));
        v = mk(.m2r(1), .regw(1));    plan.push_back(st(v, v, 0, 0));
      end
      6'b101011: begin
        v = mk(.asa(1), .asb(2'b10)); plan.push_back(st(v, v, 0, 1));
        v = mk(.iord(1), .memw(1));   plan.push_back(st(v, v, 1, 0));
      end
      6'b000000: begin
        v = mk(.asa(1), .asb(2'b00), .aop(2'b10)); plan.push_back(st(v, v, 0, 0));
        v = mk(.rdst(1), .regw(1));                plan.push_back(st(v, v, 0, 0));
      end
      6'b000100: begin
        v = mk(.asa(1), .aop(2'b01), .pcs(2'b01), .br(1)); plan.push_back(st(v, v, 0, 0));
      end
      6'b000101: if (BNE_ON) begin
        v = mk(.asa(1), .aop(2'b01), .pcs(2'b01), .br(1), .bne(1)); plan.push_back(st(v, v, 0, 0));
      end
      6'b001000: begin
        v = mk(.asa(1), .asb(2'b10)); plan.push_back(st(v, v, 0, 0));
        v = mk(.regw(1));             plan.push_back(st(v, v, 0, 0));
      end
      6'b000010: begin
        v = mk(.pcs(2'b10), .pcw(1)); plan.push_back(st(v, v, 0, 0));
      end
      default: ;
    endcase
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    Rst_n = 1'b0;
    repeat (n) begin
      Op = 6'($urandom);
      MemReady = 1'($urandom);
      exp_q.push_back(17'd0);
      tick();
    end
    Rst_n = 1'b1;
  endtask

  // stall < 0 picks 0..3 random stall cycles per memory step; abort >= 0
  // replaces that step with a two-cycle reset.
  task automatic run_instr(input logic [5:0] op, input int stall, input int abort);
    int n;
    step_t s;
    build(op);
    for (int i = 0; i < plan.size(); i++) begin
      if (i == abort) begin
        do_reset(2);
        return;
      end
      s = plan[i];
      if (s.waits) begin
        n = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
        repeat (n) begin
          Op = s.need_op ? op : 6'($urandom);
          MemReady = 1'b0;
          exp_q.push_back(s.stl);
          tick();
        end
        MemReady = 1'b1;
      end else begin
        MemReady = 1'($urandom);
      end
      Op = s.need_op ? op : 6'($urandom);
      exp_q.push_back(s.rdy);
      tick();
    end
  endtask

  initial begin : monitor
    logic [16:0] e, a;
    forever begin
      @(negedge Clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {w_bne, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, AluSrcA,
             AluSrcB, AluOp, PCSrc, PCWrite, Branch, IllegalOp};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL ctrl t=%0t got %b want %b (bne,iord,memw,irw,rdst,m2r,regw,asa,asb,aop,pcs,pcw,br,ill)",
                   $time, a, e);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    errors++;
    $display("FAIL watchdog got timeout want completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin : driver
    logic [5:0] ops[7];
    logic [5:0] op;
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010, 6'b000101};
    @(posedge Clk);
    #1;
    do_reset(2);
    run_instr(6'b100011, 0, -1);
    run_instr(6'b101011, 3, -1);
    run_instr(6'b100011, 0, 4);
    run_instr(6'b000000, 0, -1);
    run_instr(6'b000100, -1, -1);
    run_instr(6'b000010, -1, -1);
    run_instr(6'b001000, -1, -1);
    run_instr(6'b000101, 0, -1);
    run_instr(6'b111111, 0, -1);
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 9) < 8) op = ops[$urandom_range(0, 6)];
      else                          op = 6'($urandom);
      run_instr(op, -1, ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 4)) : -1);
    end
    @(negedge Clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_mc_control.md
Name: mips_mc_control

Overview:
- Main control FSM for the multicycle MIPS datapath.
- Decodes the 6-bit opcode of the instruction register and sequences fetch/decode/execute/memory/writeback states.
- Produces per-cycle datapath enables/selects plus AluOp, which feeds the ALU control decoder directly downstream.
- Stalls on a memory-ready handshake.

Parameters:
- MEM_WAIT, 1, when 1 memory states wait for MemReady; when 0 MemReady is ignored (treated as constant 1).

Ports:
- Clk  input  1  rising-edge clock
- Rst_n  input  1  synchronous, active-low reset
- Op  input  6  opcode field, Instr[31:26], from the instruction register
- MemReady  input  1  memory completed the current access this cycle
- IorD  output  1  memory address select: 0=PC, 1=ALUOut
- MemWrite  output  1  memory write strobe
- IRWrite  output  1  instruction register load
- RegDst  output  1  write register select: 0=rt, 1=rd
- MemtoReg  output  1  writeback data select: 0=ALUOut, 1=MDR
- RegWrite  output  1  register file write enable
- AluSrcA  output  1  ALU A select: 0=PC, 1=A reg
- AluSrcB  output  2  ALU B select: 00=B, 01=4, 10=SignImm, 11=SignImm<<2
- AluOp  output  2  00 add, 01 sub, 10 use funct
- PCSrc  output  2  PC select: 00=ALUResult, 01=ALUOut, 10=jump target
- PCWrite  output  1  unconditional PC load
- Branch  output  1  conditional PC load when Zero=1
- IllegalOp  output  1  one-cycle pulse on an undefined opcode

Behaviour:
- Opcodes: R=000000, LW=100011, SW=101011, BEQ=000100, ADDI=001000, J=000010.
- States, 4-bit: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, ALUWB, BEQEX, ADDIEX, ADDIWB, JEX.
- Registered state, Moore outputs. Non-listed outputs are 0.
- Reset:
  - Rst_n=0 at a rising edge -> state=FETCH. This applies mid-instruction too; the in-flight instruction is abandoned.
  - While Rst_n=0, outputs are combinationally forced: all enables (MemWrite, IRWrite, RegWrite, PCWrite, Branch, IllegalOp) = 0, all selects = 0.
- FETCH:
  - IorD=0, AluSrcA=0, AluSrcB=01, AluOp=00, PCSrc=00.
  - IRWrite=PCWrite=MemReady.
  - MemReady=0 -> stay in FETCH; MemReady=1 -> DECODE.
  - PC and IR load exactly once per instruction.
- DECODE:
  - AluSrcA=0, AluSrcB=11, AluOp=00 (branch target precompute).
  - Next state by Op: LW/SW -> MEMADR, R -> RTYPEEX, BEQ -> BEQEX, ADDI -> ADDIEX, J -> JEX.
  - Any other Op -> FETCH, with IllegalOp=1 for this DECODE cycle only.
- MEMADR: AluSrcA=1, AluSrcB=10, AluOp=00. Op=LW -> MEMRD, else MEMWR.
- MEMRD: IorD=1. Waits while MemReady=0; MemReady=1 -> MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1 -> FETCH.
- MEMWR: IorD=1, MemWrite=1, held high while waiting. MemReady=1 -> FETCH.
- RTYPEEX: AluSrcA=1, AluSrcB=00, AluOp=10 -> ALUWB.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1 -> FETCH.
- BEQEX: AluSrcA=1, AluSrcB=00, AluOp=01, PCSrc=01, Branch=1 -> FETCH.
- ADDIEX: AluSrcA=1, AluSrcB=10, AluOp=00 -> ADDIWB.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1 -> FETCH.
- JEX: PCSrc=10, PCWrite=1 -> FETCH.
- Latency in cycles with MemReady constantly 1:
  - LW=5, SW=4, R=4, ADDI=4, BEQ=3, J=3, illegal=2.
- Unreachable state encodings -> FETCH next cycle, outputs all 0.
- Op is sampled only in DECODE and MEMADR. Op changes in other states have no effect.

Optional Feature:
- Macro MIPS_BNE_EN.
- Defined:
  - Opcode 000101 (BNE) accepted in DECODE -> new state BNEEX.
  - BNEEX outputs = BEQEX outputs plus new output port BranchNe=1; the datapath loads PC when Zero=0.
  - BranchNe is 0 in all other states.
- Undefined:
  - No BranchNe port, no BNEEX state.
  - 000101 is treated as illegal: IllegalOp pulse, return to FETCH.

Decomposition:
- Package mips_pkg holds:
  - opcode localparams (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_BNE);
  - state encoding typedef/localparams;
  - AluOp codes (ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10);
  - AluSrcB and PCSrc select codes.
- Natural sub-module: mips_mc_outdec.
  - Pure combinational state -> output decode, including MemReady gating in FETCH.
  - Top keeps the state register, next-state logic, reset forcing and IllegalOp.

Test Plan:
- Reset: hold Rst_n=0 for 2 cycles while in MEMWB -> state FETCH, RegWrite=0, PCWrite=0 during reset; first cycle after release shows IRWrite=PCWrite=1 with MemReady=1.
- LW, Op=100011, MemReady=1 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; MEMWB has RegWrite=1, MemtoReg=1, RegDst=0; 5 cycles total.
- SW with MemReady low for 3 cycles in MEMWR -> MemWrite=1 for 4 consecutive cycles, then FETCH; no RegWrite.
- R-type, Op=000000 -> RTYPEEX has AluOp=10 and AluSrcB=00; ALUWB has RegDst=1, RegWrite=1.
- BEQ, Op=000100 -> BEQEX has AluOp=01, Branch=1, PCSrc=01. J, Op=000010 -> JEX has PCWrite=1, PCSrc=10.
- Op=000101 without the macro -> IllegalOp=1 for exactly one cycle in DECODE, then FETCH. With MIPS_BNE_EN -> BNEEX with BranchNe=1 and AluOp=01.
